// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - Shared state encoding and SPI mode constants for the SPI shift engine.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE
  } spi_state_e;

  // Modes are packed as {cpol, cpha}.
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_sck_gen.sv
// rtl/spi_sck_gen.sv - SCK generator: half-period divider, edge strobes and edge counter.
module spi_sck_gen #(
  parameter int DATA_W   = 32,
  parameter int HALF_DIV = 2,
  parameter int LEN_W    = $clog2(DATA_W) + 1,
  parameter int CNT_W    = LEN_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             cpol_in,
  input  logic             active,
  input  logic             shifting,
  input  logic [CNT_W-1:0] edge_limit,
  output logic             sck,
  output logic             tick,
  output logic             lead,
  output logic             trail,
  output logic             last_edge,
  output logic             edges_done
);

  localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             sck_q, sck_d;
  logic             cpol_q, cpol_d;
  logic             edge_en;

  assign tick       = (div_q == DIV_W'(HALF_DIV - 1));
  assign edge_en    = shifting && tick && (edge_cnt_q != edge_limit);
  // Odd-numbered edges (count still even) leave the idle level.
  assign lead       = edge_en && !edge_cnt_q[0];
  assign trail      = edge_en && edge_cnt_q[0];
  assign last_edge  = (edge_cnt_q == edge_limit - CNT_W'(1));
  assign edges_done = (edge_cnt_q == edge_limit);
  assign sck        = sck_q;

  always_comb begin
    div_d      = div_q;
    edge_cnt_d = edge_cnt_q;
    sck_d      = sck_q;
    cpol_d     = cpol_q;
    if (load) begin
      cpol_d     = cpol_in;
      sck_d      = cpol_in;
      div_d      = '0;
      edge_cnt_d = '0;
    end else if (!active) begin
      sck_d      = cpol_q;
      div_d      = '0;
      edge_cnt_d = '0;
    end else begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      if (edge_en) begin
        sck_d      = !sck_q;
        edge_cnt_d = edge_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q      <= '0;
      edge_cnt_q <= '0;
      sck_q      <= 1'b0;
      cpol_q     <= 1'b0;
    end else begin
      div_q      <= div_d;
      edge_cnt_q <= edge_cnt_d;
      sck_q      <= sck_d;
      cpol_q     <= cpol_d;
    end
  end

endmodule

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - SPI master shift engine: FSM, shift registers and length clamp.
// Define SPI_SHIFT_ENGINE_LSB_EN to add the lsb_first input.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int HALF_DIV = 2,
  parameter int LEN_W    = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  len,
  input  logic              cpol,
  input  logic              cpha,
`ifdef SPI_SHIFT_ENGINE_LSB_EN
  input  logic              lsb_first,
`endif
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sck,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int               CNT_W    = LEN_W + 1;
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DATA_W);

  spi_state_e        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d, len_eff;
  logic              cpha_q, cpha_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_data_q, rx_data_d, tx_align;
  logic              lsb_in, lsb_sel, accept, busy_next, tx_out;
  logic              tick, lead, trail, last_edge, edges_done;

`ifdef SPI_SHIFT_ENGINE_LSB_EN
  logic lsb_q, lsb_d;
  assign lsb_in  = lsb_first;
  assign lsb_sel = lsb_q;
  always_comb begin
    lsb_d = lsb_q;
    if (accept) lsb_d = lsb_first;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lsb_q <= 1'b0;
    else       lsb_q <= lsb_d;
  end
`else
  assign lsb_in  = 1'b0;
  assign lsb_sel = 1'b0;
`endif

  assign accept    = (state_q == ST_IDLE) && start;
  assign len_eff   = (len == '0 || len > FULL_LEN) ? FULL_LEN : len;
  // MSB-first words are pre-aligned so the first bit always leaves from the top.
  assign tx_align  = lsb_in ? tx_data : (tx_data << (FULL_LEN - len_eff));
  assign tx_out    = lsb_sel ? tx_sr_q[0] : tx_sr_q[DATA_W-1];
  assign busy_next = state_d inside {ST_SETUP, ST_SHIFT, ST_HOLD};

  spi_sck_gen #(
    .DATA_W  (DATA_W),
    .HALF_DIV(HALF_DIV),
    .LEN_W   (LEN_W),
    .CNT_W   (CNT_W)
  ) u_sck_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .cpol_in   (cpol),
    .active    (busy_next),
    .shifting  (state_q == ST_SETUP || state_q == ST_SHIFT),
    .edge_limit({len_q, 1'b0}),
    .sck       (sck),
    .tick      (tick),
    .lead      (lead),
    .trail     (trail),
    .last_edge (last_edge),
    .edges_done(edges_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SETUP;
      ST_SETUP: if (abort) state_d = ST_IDLE; else if (tick) state_d = ST_SHIFT;
      ST_SHIFT: if (abort) state_d = ST_IDLE; else if (tick && edges_done) state_d = ST_HOLD;
      ST_HOLD:  if (abort) state_d = ST_IDLE; else if (tick) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    len_d     = len_q;
    cpha_d    = cpha_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    mosi_d    = mosi_q;
    cs_n_d    = !busy_next;
    if (accept) begin
      len_d   = len_eff;
      cpha_d  = cpha;
      rx_sr_d = '0;
      if (cpha) begin
        tx_sr_d = tx_align;
        mosi_d  = 1'b0;
      end else begin
        mosi_d  = lsb_in ? tx_align[0] : tx_align[DATA_W-1];
        tx_sr_d = lsb_in ? (tx_align >> 1) : (tx_align << 1);
      end
    end else begin
      if ((cpha_q && lead) || (!cpha_q && trail && !last_edge)) begin
        mosi_d  = tx_out;
        tx_sr_d = lsb_sel ? (tx_sr_q >> 1) : (tx_sr_q << 1);
      end
      if (cpha_q ? trail : lead) begin
        rx_sr_d = lsb_sel ? {miso, rx_sr_q[DATA_W-1:1]} : {rx_sr_q[DATA_W-2:0], miso};
      end
      if (state_q == ST_HOLD && state_d == ST_DONE) begin
        rx_data_d = lsb_sel ? (rx_sr_q >> (FULL_LEN - len_q)) : rx_sr_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      cpha_q    <= 1'b0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cpha_q    <= cpha_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = state_q inside {ST_SETUP, ST_SHIFT, ST_HOLD};
  assign done    = (state_q == ST_DONE);
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;

endmodule
